multicycle_control_unit: RTL and testbench

//  Moore/Mealy FSM that sequences the 16-bit multi-cycle TSC datapath: one instruction at a time through IF/ID/EX/MEM/WB.

---
 rtl/multicycle_control_unit_if.sv | 60 ++++++
 rtl/multicycle_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundle between the multi-cycle TSC control unit and its datapath.
//   The datapath supplies the decoded instruction fields and the memory ready
//   handshake. The control unit returns every datapath control bit, its
//   current state code and the retired-instruction count.
//
//   master : control unit side (reads instruction fields, drives controls)
//   slave  : datapath side (drives instruction fields, reads controls)
//
//   opcode          IR[15:12]
//   func            IR[5:0], only meaningful when opcode == 15
//   mem_ready       memory finished the current read/write this cycle
//   ALUSrcA..IsHalted  datapath control bits
//   state           current FSM state code (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   num_inst        retired-instruction count, WORD_SIZE bits wide
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic [3:0]           opcode;
    logic [5:0]           func;
    logic                 mem_ready;

    logic                 ALUSrcA;
    logic [2:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic [1:0]           PCSource;
    logic [1:0]           BranchProperty;
    logic [1:0]           RegDest;
    logic                 RegWrite;
    logic [1:0]           RegWriteSrc;
    logic                 OutputPortWrite;
    logic                 IsLHI;
    logic                 IsHalted;
    logic [2:0]           state;
    logic [WORD_SIZE-1:0] num_inst;

    modport master (
        input  opcode, func, mem_ready,
        output ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite, IRWrite,
               PCWrite, PCWriteCond, PCSource, BranchProperty, RegDest,
               RegWrite, RegWriteSrc, OutputPortWrite, IsLHI, IsHalted,
               state, num_inst
    );

    modport slave (
        output opcode, func, mem_ready,
        input  ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite, IRWrite,
               PCWrite, PCWriteCond, PCSource, BranchProperty, RegDest,
               RegWrite, RegWriteSrc, OutputPortWrite, IsLHI, IsHalted,
               state, num_inst
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   FSM sequencing the 16-bit multi-cycle TSC datapath through IF/ID/EX/MEM/WB,
//   one instruction at a time. Decodes opcode/func from the instruction
//   register, drives every datapath control bit, stalls on mem_ready and counts
//   each retired instruction.
//
//   Parameters
//     WORD_SIZE        width of the retired-instruction counter
//     HALT_ON_ILLEGAL  1: unknown opcode/func enters HALT, 0: treated as NOP
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high; forces all controls low while high
//     bus    multicycle_control_unit_if.master (instruction fields in,
//            controls / state / num_inst out)
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int WORD_SIZE       = 16,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_control_unit_if.master      bus
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // Every control bit in one record so reset gating is a single mux.
    typedef struct packed {
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] branch_property;
        logic [1:0] reg_dest;
        logic       reg_write;
        logic [1:0] reg_write_src;
        logic       output_port_write;
        logic       is_lhi;
        logic       is_halted;
    } ctl_t;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [WORD_SIZE-1:0] count;
    logic                 retire;
    ctl_t                 ctl;
    ctl_t                 ctl_out;

    // Instruction classification; the IR is stable from ID until return to IF.
    logic is_r_type;
    logic is_r_alu;
    logic is_jpr;
    logic is_jrl;
    logic is_wwd;
    logic is_hlt;
    logic is_legal;

    assign is_r_type = (bus.opcode == OP_R);
    assign is_r_alu  = is_r_type && (bus.func < 6'd8);
    assign is_jpr    = is_r_type && (bus.func == FN_JPR);
    assign is_jrl    = is_r_type && (bus.func == FN_JRL);
    assign is_wwd    = is_r_type && (bus.func == FN_WWD);
    assign is_hlt    = is_r_type && (bus.func == FN_HLT);
    assign is_legal  = (bus.opcode <= OP_JAL) || is_r_alu || is_jpr ||
                       is_jrl || is_wwd || is_hlt;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        ctl        = '0;
        next_state = state;

        case (state)
            S_IF: begin
                // PC+1 is computed on the ALU while the fetch is outstanding.
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 3'd1;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    next_state   = S_ID;
                end
            end

            S_ID: begin
                // Speculative branch target PC+1+imm lands in ALUOut.
                ctl.alu_src_b = 3'd2;
                if (bus.opcode == OP_JMP) begin
                    ctl.pc_write  = 1'b1;
                    ctl.pc_source = 2'd2;
                    next_state    = S_IF;
                end else if (bus.opcode == OP_JAL) begin
                    ctl.pc_write      = 1'b1;
                    ctl.pc_source     = 2'd2;
                    ctl.reg_write     = 1'b1;
                    ctl.reg_dest      = 2'd2;
                    ctl.reg_write_src = 2'd2;
                    next_state        = S_IF;
                end else if (is_hlt) begin
                    next_state = S_HALT;
                end else if (is_legal) begin
                    next_state = S_EX;
                end else begin
                    next_state = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_IF;
                end
            end

            S_EX: begin
                case (bus.opcode)
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        // Compare A with B; the datapath gates PC with the flag.
                        ctl.alu_src_a       = 1'b1;
                        ctl.alu_op          = 2'd1;
                        ctl.pc_write_cond   = 1'b1;
                        ctl.pc_source       = 2'd1;
                        ctl.branch_property = bus.opcode[1:0];
                        next_state          = S_IF;
                    end
                    OP_ADI, OP_ORI, OP_LHI: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_op    = 2'd3;
                        if (bus.opcode == OP_ADI) begin
                            ctl.alu_src_b = 3'd2;
                        end else if (bus.opcode == OP_ORI) begin
                            ctl.alu_src_b = 3'd3;
                        end else begin
                            ctl.alu_src_b = 3'd4;
                            ctl.is_lhi    = 1'b1;
                        end
                        next_state = S_WB;
                    end
                    OP_LWD, OP_SWD: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = 3'd2;
                        next_state    = S_MEM;
                    end
                    OP_R: begin
                        if (is_r_alu) begin
                            ctl.alu_src_a = 1'b1;
                            ctl.alu_op    = 2'd2;
                            next_state    = S_WB;
                        end else if (is_jpr || is_jrl) begin
                            // JRL links PC (already PC+1) in the same edge that
                            // PC takes reg A.
                            ctl.pc_write  = 1'b1;
                            ctl.pc_source = 2'd3;
                            if (is_jrl) begin
                                ctl.reg_write     = 1'b1;
                                ctl.reg_dest      = 2'd2;
                                ctl.reg_write_src = 2'd2;
                            end
                            next_state = S_IF;
                        end else begin
                            ctl.output_port_write = is_wwd;
                            next_state            = S_IF;
                        end
                    end
                    default: next_state = S_IF;
                endcase
            end

            S_MEM: begin
                // Request held stable until the memory acknowledges.
                ctl.iord = 1'b1;
                if (bus.opcode == OP_LWD) begin
                    ctl.mem_read = 1'b1;
                end else begin
                    ctl.mem_write = 1'b1;
                end
                if (bus.mem_ready) begin
                    next_state = (bus.opcode == OP_LWD) ? S_WB : S_IF;
                end
            end

            S_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.reg_dest      = is_r_type ? 2'd1 : 2'd0;
                ctl.reg_write_src = (bus.opcode == OP_LWD) ? 2'd1 : 2'd0;
                next_state        = S_IF;
            end

            S_HALT: begin
                ctl.is_halted = 1'b1;
            end

            default: next_state = S_IF;
        endcase
    end

    // An instruction retires when it leaves the pipeline stages for IF or HALT.
    assign retire = ((state == S_ID) || (state == S_EX) ||
                     (state == S_MEM) || (state == S_WB)) &&
                    ((next_state == S_IF) || (next_state == S_HALT));

    // NOTE: state and counter update with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IF;
            count <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                count <= count + 1'b1;
            end
        end
    end

    // Reset acts on the outputs combinationally so an in-flight write is
    // cancelled immediately, not at the next edge.
    assign ctl_out = reset ? '0 : ctl;

    assign bus.ALUSrcA         = ctl_out.alu_src_a;
    assign bus.ALUSrcB         = ctl_out.alu_src_b;
    assign bus.ALUOp           = ctl_out.alu_op;
    assign bus.IorD            = ctl_out.iord;
    assign bus.MemRead         = ctl_out.mem_read;
    assign bus.MemWrite        = ctl_out.mem_write;
    assign bus.IRWrite         = ctl_out.ir_write;
    assign bus.PCWrite         = ctl_out.pc_write;
    assign bus.PCWriteCond     = ctl_out.pc_write_cond;
    assign bus.PCSource        = ctl_out.pc_source;
    assign bus.BranchProperty  = ctl_out.branch_property;
    assign bus.RegDest         = ctl_out.reg_dest;
    assign bus.RegWrite        = ctl_out.reg_write;
    assign bus.RegWriteSrc     = ctl_out.reg_write_src;
    assign bus.OutputPortWrite = ctl_out.output_port_write;
    assign bus.IsLHI           = ctl_out.is_lhi;
    assign bus.IsHalted        = ctl_out.is_halted;
    assign bus.state           = state;
    assign bus.num_inst        = count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed bench for multicycle_control_unit. A 16-bit instance is checked
//   cycle by cycle; a 4-bit-counter instance with HALT_ON_ILLEGAL=1 runs on the
//   same stimulus to exercise counter wrap and the illegal->HALT option.
//   Inputs change 2 time units after a rising edge, outputs are sampled 1 unit
//   later.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    typedef struct packed {
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] branch_property;
        logic [1:0] reg_dest;
        logic       reg_write;
        logic [1:0] reg_write_src;
        logic       output_port_write;
        logic       is_lhi;
        logic       is_halted;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [5:0] func;
    logic       mem_ready;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit_if #(.WORD_SIZE(16)) bus ();
    multicycle_control_unit_if #(.WORD_SIZE(4))  bus_s ();

    assign bus.opcode      = opcode;
    assign bus.func        = func;
    assign bus.mem_ready   = mem_ready;
    assign bus_s.opcode    = opcode;
    assign bus_s.func      = func;
    assign bus_s.mem_ready = mem_ready;

    multicycle_control_unit #(.WORD_SIZE(16), .HALT_ON_ILLEGAL(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    multicycle_control_unit #(.WORD_SIZE(4), .HALT_ON_ILLEGAL(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.master)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.alu_src_a         = bus.ALUSrcA;
        o.alu_src_b         = bus.ALUSrcB;
        o.alu_op            = bus.ALUOp;
        o.iord              = bus.IorD;
        o.mem_read          = bus.MemRead;
        o.mem_write         = bus.MemWrite;
        o.ir_write          = bus.IRWrite;
        o.pc_write          = bus.PCWrite;
        o.pc_write_cond     = bus.PCWriteCond;
        o.pc_source         = bus.PCSource;
        o.branch_property   = bus.BranchProperty;
        o.reg_dest          = bus.RegDest;
        o.reg_write         = bus.RegWrite;
        o.reg_write_src     = bus.RegWriteSrc;
        o.output_port_write = bus.OutputPortWrite;
        o.is_lhi            = bus.IsLHI;
        o.is_halted         = bus.IsHalted;
        return o;
    endfunction

    function automatic ctl_t c_if(input logic ready);
        ctl_t e = '0;
        e.alu_src_b = 3'd1;
        e.mem_read  = 1'b1;
        e.ir_write  = ready;
        e.pc_write  = ready;
        return e;
    endfunction

    function automatic ctl_t c_id();
        ctl_t e = '0;
        e.alu_src_b = 3'd2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ir(input logic [15:0] instr);
        opcode = instr[15:12];
        func   = instr[5:0];
    endtask

    // Check state and full control vector for the current cycle, then advance.
    task automatic step(input string tag, input logic [2:0] exp_state,
                        input ctl_t exp_ctl);
        #1;
        check({tag, ".state"}, {29'd0, bus.state}, {29'd0, exp_state});
        check({tag, ".ctl"}, {8'd0, observed()}, {8'd0, exp_ctl});
        tick();
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_num);
        #1;
        check({tag, ".state"}, {29'd0, bus.state}, {29'd0, S_IF});
        check({tag, ".num"}, {16'd0, bus.num_inst}, {16'd0, exp_num});
    endtask

    ctl_t e;

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        set_ir(16'h0000);

        // Reset held: IF decode would request a fetch, reset must mask it.
        repeat (3) begin
            tick();
            check("rst.ctl", {8'd0, observed()}, 32'd0);
            check("rst.state", {29'd0, bus.state}, {29'd0, S_IF});
            check("rst.num", {16'd0, bus.num_inst}, 32'd0);
        end
        reset = 1'b0;

        // ADD
        set_ir(16'hF0C0);
        step("add.if", S_IF, c_if(1'b1));
        step("add.id", S_ID, c_id());
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd2;
        step("add.ex", S_EX, e);
        e = '0; e.reg_write = 1'b1; e.reg_dest = 2'd1;
        step("add.wb", S_WB, e);
        check_idle("add.done", 16'd1);

        // LWD with 2 IF wait cycles and 3 MEM wait cycles: 10 cycles total
        set_ir(16'h7105);
        mem_ready = 1'b0;
        step("lwd.if_w0", S_IF, c_if(1'b0));
        step("lwd.if_w1", S_IF, c_if(1'b0));
        mem_ready = 1'b1;
        step("lwd.if", S_IF, c_if(1'b1));
        step("lwd.id", S_ID, c_id());
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 3'd2;
        step("lwd.ex", S_EX, e);
        mem_ready = 1'b0;
        e = '0; e.iord = 1'b1; e.mem_read = 1'b1;
        step("lwd.mem_w0", S_MEM, e);
        step("lwd.mem_w1", S_MEM, e);
        step("lwd.mem_w2", S_MEM, e);
        mem_ready = 1'b1;
        step("lwd.mem", S_MEM, e);
        e = '0; e.reg_write = 1'b1; e.reg_write_src = 2'd1;
        step("lwd.wb", S_WB, e);
        check_idle("lwd.done", 16'd2);

        // BEQ
        set_ir(16'h1102);
        step("beq.if", S_IF, c_if(1'b1));
        step("beq.id", S_ID, c_id());
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write_cond = 1'b1;
        e.pc_source = 2'd1; e.branch_property = 2'd1;
        step("beq.ex", S_EX, e);
        check_idle("beq.done", 16'd3);

        // JAL
        set_ir(16'hA123);
        step("jal.if", S_IF, c_if(1'b1));
        e = c_id(); e.pc_write = 1'b1; e.pc_source = 2'd2; e.reg_write = 1'b1;
        e.reg_dest = 2'd2; e.reg_write_src = 2'd2;
        step("jal.id", S_ID, e);
        check_idle("jal.done", 16'd4);

        // LHI
        set_ir(16'h6203);
        step("lhi.if", S_IF, c_if(1'b1));
        step("lhi.id", S_ID, c_id());
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 3'd4; e.alu_op = 2'd3;
        e.is_lhi = 1'b1;
        step("lhi.ex", S_EX, e);
        e = '0; e.reg_write = 1'b1;
        step("lhi.wb", S_WB, e);
        check_idle("lhi.done", 16'd5);

        // WWD: output port strobe lasts exactly the EX cycle
        set_ir(16'hF01C);
        step("wwd.if", S_IF, c_if(1'b1));
        step("wwd.id", S_ID, c_id());
        e = '0; e.output_port_write = 1'b1;
        step("wwd.ex", S_EX, e);
        check_idle("wwd.done", 16'd6);
        check("wwd.strobe_off", {31'd0, bus.OutputPortWrite}, 32'd0);

        // JRL
        set_ir(16'hF01A);
        step("jrl.if", S_IF, c_if(1'b1));
        step("jrl.id", S_ID, c_id());
        e = '0; e.pc_write = 1'b1; e.pc_source = 2'd3; e.reg_write = 1'b1;
        e.reg_dest = 2'd2; e.reg_write_src = 2'd2;
        step("jrl.ex", S_EX, e);
        check_idle("jrl.done", 16'd7);

        // Illegal opcode: NOP on the main instance, HALT on the other
        set_ir(16'hB000);
        step("ill.if", S_IF, c_if(1'b1));
        step("ill.id", S_ID, c_id());
        check_idle("ill.done", 16'd8);
        check("ill.s_state", {29'd0, bus_s.state}, {29'd0, S_HALT});
        check("ill.s_num", {28'd0, bus_s.num_inst}, 32'd8);

        // HLT: stays halted, counter frozen, async reset releases it
        set_ir(16'hF01D);
        step("hlt.if", S_IF, c_if(1'b1));
        step("hlt.id", S_ID, c_id());
        e = '0; e.is_halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("hlt.state", {29'd0, bus.state}, {29'd0, S_HALT});
            check("hlt.ctl", {8'd0, observed()}, {8'd0, e});
            check("hlt.num", {16'd0, bus.num_inst}, 32'd9);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("hlt.rst_state", {29'd0, bus.state}, {29'd0, S_IF});
        check("hlt.rst_ctl", {8'd0, observed()}, 32'd0);
        check("hlt.rst_num", {16'd0, bus.num_inst}, 32'd0);
        check("hlt.rst_s_state", {29'd0, bus_s.state}, {29'd0, S_IF});
        tick();
        reset = 1'b0;

        // JMP so the counter is nonzero before the mid-MEM reset
        set_ir(16'h9000);
        step("jmp.if", S_IF, c_if(1'b1));
        e = c_id(); e.pc_write = 1'b1; e.pc_source = 2'd2;
        step("jmp.id", S_ID, e);
        check_idle("jmp.done", 16'd1);

        // SWD aborted by reset while waiting in MEM
        set_ir(16'h8204);
        step("swd.if", S_IF, c_if(1'b1));
        step("swd.id", S_ID, c_id());
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 3'd2;
        step("swd.ex", S_EX, e);
        mem_ready = 1'b0;
        e = '0; e.iord = 1'b1; e.mem_write = 1'b1;
        step("swd.mem_w0", S_MEM, e);
        #1;
        check("swd.mem_w1", {8'd0, observed()}, {8'd0, e});
        reset = 1'b1;
        #1;
        check("swd.rst_ctl", {8'd0, observed()}, 32'd0);
        check("swd.rst_state", {29'd0, bus.state}, {29'd0, S_IF});
        check("swd.rst_num", {16'd0, bus.num_inst}, 32'd0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;

        // Counter wrap on the 4-bit instance: 15 JMPs, then one more
        set_ir(16'h9000);
        repeat (30) tick();
        check_idle("wrap.15", 16'd15);
        check("wrap.s_15", {28'd0, bus_s.num_inst}, 32'd15);
        repeat (2) tick();
        check_idle("wrap.16", 16'd16);
        check("wrap.s_0", {28'd0, bus_s.num_inst}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
